// File: rtl/sa_ctrl_pkg.sv
// Shared definitions for the systolic-array control slave.
// Holds the register map byte offsets, bit positions inside CTRL and STATUS,
// the AXI response encoding, the default IP identifier and small helpers
// used by the register file and the write-capture block.
package sa_ctrl_pkg;

  // Register byte offsets within the 64-byte window
  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_SRC    = 6'h08;
  localparam logic [5:0] ADDR_WGT    = 6'h0C;
  localparam logic [5:0] ADDR_DST    = 6'h10;
  localparam logic [5:0] ADDR_SIZE   = 6'h14;
  localparam logic [5:0] ADDR_CYCLES = 6'h18;
  localparam logic [5:0] ADDR_ID     = 6'h1C;

  // CTRL bits
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;

  // STATUS bits
  localparam int ST_BUSY_BIT = 0;
  localparam int ST_DONE_BIT = 1;
  localparam int ST_ERR_BIT  = 2;
  localparam int ST_REJ_BIT  = 3;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_e;

  localparam logic [31:0] SA_IP_ID = 32'h5A01_0001;

  // Offsets 0x20 and above have no register behind them
  function automatic logic is_mapped(input logic [5:0] off);
    return (off < 6'h20);
  endfunction

  // Byte-lane merge of a write into an existing 32-bit register
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (wstrb[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sa_axil_wr_capture.sv
// AXI4-Lite write-side capture: one-entry holding registers for the AW and W
// channels and the B-channel handshake.
// Ports:
//   aclk_i, aresetn_i          clock, asynchronous active-low reset
//   awaddr_i/awvalid_i/awready_o   word address (byte lanes already dropped)
//   wdata_i/wstrb_i/wvalid_i/wready_o
//   bresp_o/bvalid_o/bready_i
//   commit_o                   single-cycle strobe when both entries are held
//                              and no response is outstanding
//   commit_addr_o/data_o/strb_o    the held transaction
//   commit_resp_i              response chosen by the register file at commit
module sa_axil_wr_capture
  import sa_ctrl_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                aclk_i,
  input  logic                aresetn_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  output logic                commit_o,
  output logic [ADDR_W-1:0]   commit_addr_o,
  output logic [DATA_W-1:0]   commit_data_o,
  output logic [DATA_W/8-1:0] commit_strb_o,
  input  resp_e               commit_resp_i
);

  logic                aw_full_q, aw_full_d;
  logic                w_full_q,  w_full_d;
  logic                bvalid_q,  bvalid_d;
  resp_e               bresp_q,   bresp_d;
  logic [ADDR_W-1:0]   awaddr_q,  awaddr_d;
  logic [DATA_W-1:0]   wdata_q,   wdata_d;
  logic [DATA_W/8-1:0] wstrb_q,   wstrb_d;
  logic                b_hs;

  // Entries stay held through the response so only one write is in flight
  assign awready_o     = ~aw_full_q;
  assign wready_o      = ~w_full_q;
  assign commit_o      = aw_full_q & w_full_q & ~bvalid_q;
  assign b_hs          = bvalid_q & bready_i;
  assign bvalid_o      = bvalid_q;
  assign bresp_o       = bresp_q;
  assign commit_addr_o = awaddr_q;
  assign commit_data_o = wdata_q;
  assign commit_strb_o = wstrb_q;

  always_comb begin
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    // B handshake frees both entries; READYs come back next cycle
    if (b_hs) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
      bvalid_d  = 1'b0;
    end
    if (awvalid_i && !aw_full_q) begin
      aw_full_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (wvalid_i && !w_full_q) begin
      w_full_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (commit_o) begin
      bvalid_d = 1'b1;
      bresp_d  = commit_resp_i;
    end
  end

  always_ff @(posedge aclk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= OKAY;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
    end
  end

endmodule

// File: rtl/sa_ctrl_axil_slave.sv
// AXI4-Lite register file that programs and monitors the systolic-array core.
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN      clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*/AR*/R*          AXI4-Lite slave channels (64-byte window)
//   o_start                        one-cycle start pulse to the core
//   o_src_addr/o_wgt_addr/o_dst_addr/o_size_param   job configuration
//   i_busy, i_done, i_error        core status (done is a level)
//   o_irq                          level interrupt, IRQ_EN & (DONE | ERR)
module sa_ctrl_axil_slave
  import sa_ctrl_pkg::*;
#(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 6,
  parameter logic [31:0] IP_ID              = SA_IP_ID
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic                            o_start,
  output logic [31:0]                     o_src_addr,
  output logic [31:0]                     o_wgt_addr,
  output logic [31:0]                     o_dst_addr,
  output logic [31:0]                     o_size_param,
  input  logic                            i_busy,
  input  logic                            i_done,
  input  logic                            i_error,
  output logic                            o_irq
);

  localparam int WORD_W = C_S_AXI_ADDR_WIDTH - 2;

  // Byte-lane address bits carry no meaning in a word-aligned map
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // ---------------------------------------------------------------- write capture
  logic                            wr_commit;
  logic [WORD_W-1:0]               wr_word;
  logic [C_S_AXI_DATA_WIDTH-1:0]   wr_data;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] wr_strb;
  resp_e                           wr_resp;

  sa_axil_wr_capture #(
    .ADDR_W (WORD_W),
    .DATA_W (C_S_AXI_DATA_WIDTH)
  ) u_wr_capture (
    .aclk_i        (S_AXI_ACLK),
    .aresetn_i     (S_AXI_ARESETN),
    .awaddr_i      (S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2]),
    .awvalid_i     (S_AXI_AWVALID),
    .awready_o     (S_AXI_AWREADY),
    .wdata_i       (S_AXI_WDATA),
    .wstrb_i       (S_AXI_WSTRB),
    .wvalid_i      (S_AXI_WVALID),
    .wready_o      (S_AXI_WREADY),
    .bresp_o       (S_AXI_BRESP),
    .bvalid_o      (S_AXI_BVALID),
    .bready_i      (S_AXI_BREADY),
    .commit_o      (wr_commit),
    .commit_addr_o (wr_word),
    .commit_data_o (wr_data),
    .commit_strb_o (wr_strb),
    .commit_resp_i (wr_resp)
  );

  // ---------------------------------------------------------------- register file
  logic        irq_en_q,   irq_en_d;
  logic        done_q,     done_d;
  logic        err_q,      err_d;
  logic        rej_q,      rej_d;
  logic [31:0] src_q,      src_d;
  logic [31:0] wgt_q,      wgt_d;
  logic [31:0] dst_q,      dst_d;
  logic [31:0] size_q,     size_d;
  logic [31:0] cycles_q,   cycles_d;
  logic        start_q,    start_d;
  logic        irq_q,      irq_d;
  logic        done_prev_q, err_prev_q;

  logic [C_S_AXI_ADDR_WIDTH-1:0] wr_off;
  logic                          wr_is_cfg;
  logic                          wr_ok;

  assign wr_off    = {wr_word, 2'b00};
  assign wr_is_cfg = (wr_off == ADDR_SRC) || (wr_off == ADDR_WGT) ||
                     (wr_off == ADDR_DST) || (wr_off == ADDR_SIZE);
  // Job configuration is frozen while the core is running
  assign wr_resp   = (!is_mapped(wr_off) || (wr_is_cfg && i_busy)) ? SLVERR : OKAY;
  assign wr_ok     = wr_commit && (wr_resp == OKAY);

  always_comb begin
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    rej_d    = rej_q;
    src_d    = src_q;
    wgt_d    = wgt_q;
    dst_d    = dst_q;
    size_d   = size_q;
    cycles_d = cycles_q;
    start_d  = 1'b0;

    if (wr_ok) begin
      case (wr_off)
        ADDR_CTRL: begin
          if (wr_strb[0]) begin
            irq_en_d = wr_data[CTRL_IRQ_EN_BIT];
            if (wr_data[CTRL_START_BIT]) begin
              if (i_busy) rej_d   = 1'b1;
              else        start_d = 1'b1;
            end
          end
        end
        ADDR_STATUS: begin
          if (wr_strb[0]) begin
            done_d = done_q & ~wr_data[ST_DONE_BIT];
            err_d  = err_q  & ~wr_data[ST_ERR_BIT];
            rej_d  = rej_q  & ~wr_data[ST_REJ_BIT];
          end
        end
        ADDR_SRC:  src_d  = apply_wstrb(src_q,  wr_data, wr_strb);
        ADDR_WGT:  wgt_d  = apply_wstrb(wgt_q,  wr_data, wr_strb);
        ADDR_DST:  dst_d  = apply_wstrb(dst_q,  wr_data, wr_strb);
        ADDR_SIZE: size_d = apply_wstrb(size_q, wr_data, wr_strb);
        default: ;
      endcase
    end

    // Status edges are applied after the W1C so a same-cycle set survives
    if (i_done  && !done_prev_q) done_d = 1'b1;
    if (i_error && !err_prev_q)  err_d  = 1'b1;

    // The start pulse owns the counter in its cycle
    if (start_q)                          cycles_d = '0;
    else if (i_busy && (cycles_q != '1))  cycles_d = cycles_q + 32'd1;

    irq_d = irq_en_q & (done_q | err_q);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      irq_en_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rej_q       <= 1'b0;
      src_q       <= '0;
      wgt_q       <= '0;
      dst_q       <= '0;
      size_q      <= '0;
      cycles_q    <= '0;
      start_q     <= 1'b0;
      irq_q       <= 1'b0;
      done_prev_q <= 1'b0;
      err_prev_q  <= 1'b0;
    end else begin
      irq_en_q    <= irq_en_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rej_q       <= rej_d;
      src_q       <= src_d;
      wgt_q       <= wgt_d;
      dst_q       <= dst_d;
      size_q      <= size_d;
      cycles_q    <= cycles_d;
      start_q     <= start_d;
      irq_q       <= irq_d;
      done_prev_q <= i_done;
      err_prev_q  <= i_error;
    end
  end

  assign o_start      = start_q;
  assign o_src_addr   = src_q;
  assign o_wgt_addr   = wgt_q;
  assign o_dst_addr   = dst_q;
  assign o_size_param = size_q;
  assign o_irq        = irq_q;

  // ---------------------------------------------------------------- read path
  logic                          rvalid_q, rvalid_d;
  logic [31:0]                   rdata_q,  rdata_d;
  resp_e                         rresp_q,  rresp_d;
  logic [C_S_AXI_ADDR_WIDTH-1:0] rd_off;
  logic                          ar_hs;
  logic [31:0]                   rd_val;
  resp_e                         rd_resp;

  assign rd_off = {S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2], 2'b00};
  assign ar_hs  = S_AXI_ARVALID & ~rvalid_q;

  always_comb begin
    rd_val  = '0;
    rd_resp = OKAY;
    case (rd_off)
      ADDR_CTRL:   rd_val[CTRL_IRQ_EN_BIT] = irq_en_q;
      ADDR_STATUS: begin
        rd_val[ST_BUSY_BIT] = i_busy;
        rd_val[ST_DONE_BIT] = done_q;
        rd_val[ST_ERR_BIT]  = err_q;
        rd_val[ST_REJ_BIT]  = rej_q;
      end
      ADDR_SRC:    rd_val = src_q;
      ADDR_WGT:    rd_val = wgt_q;
      ADDR_DST:    rd_val = dst_q;
      ADDR_SIZE:   rd_val = size_q;
      ADDR_CYCLES: rd_val = cycles_q;
      ADDR_ID:     rd_val = IP_ID;
      default:     rd_resp = SLVERR;
    endcase
  end

  always_comb begin
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_val;
      rresp_d  = rd_resp;
    end else if (rvalid_q && S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= OKAY;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
    end
  end

  assign S_AXI_ARREADY = ~rvalid_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_sa_ctrl_axil_slave.sv
// Self-checking bench for sa_ctrl_axil_slave: directed AXI-Lite transactions,
// a register-level model of the block and a per-cycle output comparison.
module tb_sa_ctrl_axil_slave;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [5:0]  araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        o_start;
  logic [31:0] o_src, o_wgt, o_dst, o_size;
  logic        i_busy = 1'b0, i_done = 1'b0, i_error = 1'b0;
  logic        o_irq;

  always #5 clk = ~clk;

  sa_ctrl_axil_slave dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rstn),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .o_start       (o_start),
    .o_src_addr    (o_src),
    .o_wgt_addr    (o_wgt),
    .o_dst_addr    (o_dst),
    .o_size_param  (o_size),
    .i_busy        (i_busy),
    .i_done        (i_done),
    .i_error       (i_error),
    .o_irq         (o_irq)
  );

  int checks = 0;
  int errors = 0;

  // Register-level model of the block
  logic [31:0] m_src = '0, m_wgt = '0, m_dst = '0, m_size = '0, m_cycles = '0;
  bit m_en, m_done, m_err, m_rej, m_irq, m_prev_done, m_prev_err, m_start_now;
  int start_cnt = 0;

  logic [31:0] last_rdata;
  logic [1:0]  last_rresp;
  logic [1:0]  last_bresp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_src = '0; m_wgt = '0; m_dst = '0; m_size = '0; m_cycles = '0;
    m_en = 0; m_done = 0; m_err = 0; m_rej = 0; m_irq = 0;
    m_prev_done = 0; m_prev_err = 0; m_start_now = 0;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Effect of a committed write on the model; returns the required response
  task automatic model_write(input logic [5:0] addr, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] exp_resp);
    int word;
    word = int'(addr) / 4;
    exp_resp = 2'b00;
    if (word >= 8) begin
      exp_resp = 2'b10;
    end else if (word >= 2 && word <= 5 && i_busy) begin
      exp_resp = 2'b10;
    end else begin
      case (word)
        0: if (s[0]) begin
             m_en = d[1];
             if (d[0]) begin
               if (i_busy) m_rej = 1;
               else        m_start_now = 1;
             end
           end
        1: if (s[0]) begin
             if (d[1]) m_done = 0;
             if (d[2]) m_err = 0;
             if (d[3]) m_rej = 0;
           end
        2: m_src  = merge(m_src,  d, s);
        3: m_wgt  = merge(m_wgt,  d, s);
        4: m_dst  = merge(m_dst,  d, s);
        5: m_size = merge(m_size, d, s);
        default: ;
      endcase
    end
  endtask

  task automatic model_read(input logic [5:0] addr, output logic [31:0] d,
                            output logic [1:0] r);
    int word;
    word = int'(addr) / 4;
    r = 2'b00;
    case (word)
      0: d = {30'd0, m_en, 1'b0};
      1: d = {28'd0, m_rej, m_err, m_done, i_busy};
      2: d = m_src;
      3: d = m_wgt;
      4: d = m_dst;
      5: d = m_size;
      6: d = m_cycles;
      7: d = 32'h5A01_0001;
      default: begin d = '0; r = 2'b10; end
    endcase
  endtask

  // Called at a falling edge. W may lead AW by w_lead cycles; BREADY is
  // withheld for b_delay cycles once BVALID appears.
  task automatic axi_write(input string name, input logic [5:0] addr, input logic [31:0] d,
                           input logic [3:0] s, input int w_lead, input int b_delay);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    logic [1:0] exp_resp;
    aw_done = 0; w_done = 0; n = 0;
    awaddr = addr; wdata = d; wstrb = s; wvalid = 1'b1;
    awvalid = (w_lead == 0);
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      @(negedge clk); n++;
      if (aw_hs) begin awvalid = 1'b0; aw_done = 1; end
      if (w_hs)  begin wvalid  = 1'b0; w_done  = 1; end
      if (!aw_done && n >= w_lead) awvalid = 1'b1;
      if (w_done && !aw_done) chk({name, "_wready_held"}, wready, 0);
    end
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk({name, "_bvalid_seen"}, bvalid, 1);
    if (!bvalid) return;
    model_write(addr, d, s, exp_resp);
    chk({name, "_bresp"}, bresp, exp_resp);
    last_bresp = bresp;
    for (int i = 0; i < b_delay; i++) begin
      @(negedge clk);
      chk({name, "_bvalid_hold"}, bvalid, 1);
      chk({name, "_awready_low"}, awready, 0);
      chk({name, "_wready_low"}, wready, 0);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk({name, "_bvalid_clr"}, bvalid, 0);
    chk({name, "_awready_back"}, awready, 1);
    chk({name, "_wready_back"}, wready, 1);
  endtask

  task automatic axi_read(input string name, input logic [5:0] addr);
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    bit hs;
    int n;
    model_read(addr, exp_d, exp_r);
    araddr = addr; arvalid = 1'b1; n = 0; hs = 0;
    while (!hs && n < 20) begin
      hs = arready;
      @(negedge clk); n++;
    end
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk({name, "_rvalid_seen"}, rvalid, 1);
    chk({name, "_rdata"}, rdata, exp_d);
    chk({name, "_rresp"}, rresp, exp_r);
    last_rdata = rdata;
    last_rresp = rresp;
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk({name, "_rvalid_clr"}, rvalid, 0);
    chk({name, "_arready_back"}, arready, 1);
  endtask

  initial begin
    model_reset();
    fork
      // Model time step: status edges, cycle counter and the registered irq
      forever begin
        @(posedge clk);
        if (!rstn) begin
          model_reset();
        end else begin
          m_irq = m_en & (m_done | m_err);
          if (i_done && !m_prev_done) m_done = 1;
          if (i_error && !m_prev_err) m_err = 1;
          m_prev_done = i_done;
          m_prev_err  = i_error;
          if (m_start_now) begin
            m_cycles = '0;
            m_start_now = 0;
          end else if (i_busy && m_cycles != 32'hFFFF_FFFF) begin
            m_cycles = m_cycles + 1;
          end
        end
      end
      // Per-cycle comparison of the core-facing outputs
      forever begin
        @(negedge clk);
        #2;
        if (o_start === 1'b1) start_cnt++;
        chk("o_src_addr", o_src, m_src);
        chk("o_wgt_addr", o_wgt, m_wgt);
        chk("o_dst_addr", o_dst, m_dst);
        chk("o_size_param", o_size, m_size);
        chk("o_start", o_start, m_start_now);
        chk("o_irq", o_irq, m_irq);
      end
      begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_arready", arready, 1);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_start", o_start, 0);
    chk("rst_irq", o_irq, 0);
    rstn = 1'b1;
    @(negedge clk);

    // Configuration writes and read-back
    axi_write("w_src",  6'h08, 32'h1000_0000, 4'hF, 0, 0);
    chk("w_src_okay", last_bresp, 2'b00);
    axi_write("w_wgt",  6'h0C, 32'h1000_1000, 4'hF, 0, 0);
    axi_write("w_dst",  6'h10, 32'h2000_0000, 4'hF, 0, 0);
    axi_write("w_size", 6'h14, 32'h0000_0020, 4'hF, 0, 0);
    chk("src_lit", o_src, 32'h1000_0000);
    chk("size_lit", o_size, 32'h0000_0020);
    axi_read("r_src", 6'h08);
    axi_read("r_wgt", 6'h0C);
    axi_read("r_dst", 6'h10);
    axi_read("r_size", 6'h14);
    chk("dst_rd_lit", o_dst, 32'h2000_0000);
    chk("no_start_yet", start_cnt, 0);

    // W three cycles ahead of AW, BREADY held off five cycles
    axi_write("w_lead", 6'h0C, 32'h1234_5678, 4'hF, 3, 5);
    chk("wgt_lit", o_wgt, 32'h1234_5678);

    // Start, 100 busy cycles, done edge, interrupt and its W1C
    axi_write("w_start", 6'h00, 32'h0000_0003, 4'hF, 0, 0);
    chk("start_pulses", start_cnt, 1);
    i_busy = 1'b1;
    repeat (100) @(negedge clk);
    i_busy = 1'b0;
    i_done = 1'b1;
    repeat (3) @(negedge clk);
    axi_read("r_cycles", 6'h18);
    chk("cycles_lit", last_rdata, 32'd100);
    axi_read("r_status_done", 6'h04);
    chk("status_done_lit", last_rdata, 32'h2);
    chk("irq_on_lit", o_irq, 1);
    axi_write("w_clr_done", 6'h04, 32'h0000_0002, 4'hF, 0, 0);
    repeat (2) @(negedge clk);
    chk("irq_off_lit", o_irq, 0);
    i_done = 1'b0;

    // Busy core: start rejected, configuration write refused
    i_busy = 1'b1;
    @(negedge clk);
    axi_write("w_start_busy", 6'h00, 32'h0000_0001, 4'hF, 0, 0);
    chk("start_busy_okay", last_bresp, 2'b00);
    axi_read("r_status_rej", 6'h04);
    chk("status_rej_lit", last_rdata, 32'h9);
    axi_write("w_src_busy", 6'h08, 32'hDEAD_BEEF, 4'hF, 0, 0);
    chk("src_busy_slverr", last_bresp, 2'b10);
    axi_read("r_src_busy", 6'h08);
    chk("src_kept_lit", last_rdata, 32'h1000_0000);
    chk("start_pulses_2", start_cnt, 1);
    i_busy = 1'b0;
    @(negedge clk);
    axi_write("w_clr_rej", 6'h04, 32'h0000_0008, 4'hF, 0, 0);

    // Error edge raises the interrupt when enabled
    axi_write("w_irq_en", 6'h00, 32'h0000_0002, 4'hF, 0, 0);
    i_error = 1'b1;
    @(negedge clk);
    i_error = 1'b0;
    repeat (3) @(negedge clk);
    chk("irq_err_lit", o_irq, 1);
    axi_read("r_status_err", 6'h04);
    chk("status_err_lit", last_rdata, 32'h4);
    axi_write("w_clr_err", 6'h04, 32'h0000_0004, 4'hF, 0, 0);
    repeat (2) @(negedge clk);

    // Unmapped window and ID
    axi_read("r_unmapped", 6'h24);
    chk("unmapped_rresp_lit", last_rresp, 2'b10);
    chk("unmapped_rdata_lit", last_rdata, 32'h0);
    axi_write("w_unmapped", 6'h24, 32'hFFFF_FFFF, 4'hF, 0, 0);
    chk("unmapped_bresp_lit", last_bresp, 2'b10);
    axi_read("r_id", 6'h1C);
    chk("id_lit", last_rdata, 32'h5A01_0001);
    axi_write("w_id_ro", 6'h1F, 32'h0, 4'hF, 0, 0);
    axi_read("r_id_again", 6'h1C);

    // Byte strobes
    axi_write("w_src_full", 6'h08, 32'h1111_1111, 4'hF, 0, 0);
    axi_write("w_src_strb", 6'h08, 32'hAABB_CCDD, 4'b0010, 0, 0);
    chk("src_strb_lit", o_src, 32'h1111_CC11);
    axi_read("r_src_strb", 6'h09);

    // Reset in the middle of a read response
    araddr = 6'h1C; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("mid_rvalid_up", rvalid, 1);
    #3;
    rstn = 1'b0;
    model_reset();
    #1;
    chk("mid_rvalid_rst", rvalid, 0);
    chk("mid_arready_rst", arready, 1);
    chk("mid_rdata_rst", rdata, 0);
    chk("mid_src_rst", o_src, 0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    axi_read("r_src_after_rst", 6'h08);
    axi_read("r_ctrl_after_rst", 6'h00);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sa_ctrl_axil_slave.md
Name: sa_ctrl_axil_slave

Overview:
- AXI4-Lite slave register file that programs and monitors the systolic-array core pipeline.
- Drives i_start, src/wgt/dst addresses and size_param into the core.
- Captures the core's busy/done/error status, counts busy cycles and raises a level interrupt.
- Sits between the PS AXI-Lite interconnect and the core, on S_AXI_ACLK.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 6, byte address width (64-byte window).
- IP_ID, 32'h5A01_0001, constant returned by the ID register.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset: asynchronous, active-low, clock S_AXI_ACLK.
- S_AXI_AWADDR/AWVALID/AWREADY  in/in/out  6/1/1  write address channel.
- S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  32/4/1/1  write data channel.
- S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel.
- S_AXI_ARADDR/ARVALID/ARREADY  in/in/out  6/1/1  read address channel.
- S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  32/2/1/1  read data channel.
- o_start  out  1  one-cycle start pulse to the core.
- o_src_addr, o_wgt_addr, o_dst_addr, o_size_param  out  32 each  register values.
- i_busy, i_done, i_error  in  1 each  core status; i_done is level, cleared by the core on start.
- o_irq  out  1  level interrupt.

Behaviour:
- Register map (word-aligned; AWADDR/ARADDR[1:0] ignored):
  - 0x00 CTRL RW: [0] START write-1 (reads 0), [1] IRQ_EN.
  - 0x04 STATUS: [0] BUSY RO (i_busy), [1] DONE W1C sticky, [2] ERR W1C sticky, [3] START_REJ W1C sticky.
  - 0x08 SRC, 0x0C WGT, 0x10 DST, 0x14 SIZE: RW.
  - 0x18 CYCLES RO.
  - 0x1C ID RO.
  - 0x20-0x3C unmapped.
- Reset values:
  - All registers 0.
  - AWREADY=WREADY=ARREADY=1; BVALID=RVALID=0; BRESP=RRESP=0; RDATA=0.
  - o_start=0, o_irq=0.
- Write path:
  - AW and W are accepted independently, in either order or the same cycle.
  - Each is held in a one-entry holding register; its READY drops while the entry is held.
  - Commit occurs in the cycle both entries are held and BVALID=0.
  - BVALID rises the cycle after commit and stays high until BREADY; both READYs reassert the cycle after the B handshake.
  - Maximum one outstanding write.
- WSTRB applies per byte to RW registers; W1C/W1S bits act only where strobe byte 0 is set.
- BRESP:
  - OKAY for mapped addresses.
  - SLVERR for unmapped addresses; no state change.
  - SLVERR for writes to SRC/WGT/DST/SIZE while i_busy=1; write ignored.
  - Writes to RO registers get OKAY and are ignored.
- Read path:
  - ARREADY=1 when RVALID=0.
  - On the AR handshake, RDATA/RRESP are registered and RVALID rises the next cycle, held until RREADY.
  - ARREADY reasserts the cycle after the R handshake.
  - Unmapped address: RDATA=0, RRESP=SLVERR.
  - Reads and writes are independent and concurrent.
- Start:
  - A committed CTRL write with START=1 and i_busy=0 asserts o_start for exactly 1 cycle, on the cycle after commit.
  - If i_busy=1, no pulse and START_REJ is set.
  - The pulse also clears CYCLES to 0.
- DONE/ERR: set on a rising edge of i_done / i_error (registered previous value, reset 0). Same-cycle set and W1C: set wins.
- CYCLES: increments by 1 each cycle i_busy=1 and saturates at 32'hFFFF_FFFF. Same-cycle start pulse and increment: clear wins.
- o_irq = IRQ_EN & (DONE | ERR), registered with 1-cycle latency.
- Reset mid-transaction: all channels return to reset values immediately; the pending response is lost.

Decomposition:
- Package sa_ctrl_pkg holds:
  - register offset localparams (ADDR_CTRL…ADDR_ID);
  - bit-index constants;
  - resp_e enum (OKAY=2'b00, SLVERR=2'b10);
  - ID constant.
- One natural sub-module: sa_axil_wr_capture, covering AW/W holding registers and the B-channel handshake.
- The read path and register file stay in the top.

Test Plan:
- Reset, then write SRC=0x1000_0000, WGT=0x1000_1000, DST=0x2000_0000, SIZE=0x20 and read each back -> BRESP/RRESP OKAY, outputs match, o_start stays 0.
- W presented 3 cycles before AW, with BREADY held low 5 cycles -> single commit, BVALID stays high until BREADY, AWREADY/WREADY low until after the B handshake.
- Write CTRL=0x3 with i_busy=0, then core raises busy for 100 cycles and a done edge -> one o_start pulse, CYCLES reads 100, DONE=1, o_irq=1; W1C STATUS=0x2 -> o_irq=0.
- While i_busy=1: write CTRL=0x1 -> no pulse, START_REJ=1; write SRC -> SLVERR, value unchanged.
- Access 0x24: read -> RDATA 0, SLVERR; write -> SLVERR; ID read -> 0x5A01_0001.
- Write SRC with WSTRB=4'b0010, data 0xAABBCCDD, onto SRC=0x1111_1111 -> SRC=0x1111_CC11; assert reset mid-read -> RVALID=0 immediately.
